// File: rtl/spi_slave_core_if.sv
// Wishbone register bus of the SPI slave core, plus its interrupt line.
//   master : CPU side; drives address/data/select/write-enable/strobe/cycle,
//            receives read data, acknowledge and interrupt.
//   slave  : the SPI slave core; the mirror image of master.
interface spi_slave_core_if;
  logic [4:0]  wb_adr_in;
  logic [31:0] wb_dat_in;
  logic [3:0]  wb_sel_in;
  logic        wb_we_in;
  logic        wb_stb_in;
  logic        wb_cyc_in;
  logic [31:0] wb_dat_o;
  logic        wb_ack_out;
  logic        wb_int_o;

  modport master (
    output wb_adr_in, wb_dat_in, wb_sel_in, wb_we_in, wb_stb_in, wb_cyc_in,
    input  wb_dat_o, wb_ack_out, wb_int_o
  );

  modport slave (
    input  wb_adr_in, wb_dat_in, wb_sel_in, wb_we_in, wb_stb_in, wb_cyc_in,
    output wb_dat_o, wb_ack_out, wb_int_o
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI slave (target) with a Wishbone register interface. sclk/ss_n/mosi are
// oversampled in the wb_clk_in domain; characters of 1..CHAR_LEN_MAX bits are
// received into RX and returned from TX in any of the four SPI modes.
// Ports:
//   wb_clk_in, wb_rst_in : system clock, asynchronous active-high reset
//   wb                   : Wishbone slave bus + level interrupt (spi_slave_core_if)
//   sclk_in, ss_n_in     : serial clock and active-low select from the master
//   mosi_in, miso_out    : serial data in / out
//   miso_oe              : miso driver enable (selected and enabled)
// Registers: 0x00 RX(read)/TX(write), 0x10 CTRL, 0x14 STATUS.
module spi_slave_core #(
  parameter int CHAR_LEN_MAX = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              wb_clk_in,
  input  logic              wb_rst_in,
  spi_slave_core_if.slave   wb,
  input  logic              sclk_in,
  input  logic              ss_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe
);
  localparam int CW = $clog2(CHAR_LEN_MAX + 1);
  localparam int IW = $clog2(CHAR_LEN_MAX);
  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_STAT = 5'h14;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]    r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                      r_sclk_d, r_ss_d;
  logic                      r_ack, r_int;
  logic [31:0]               r_dat_o;
  logic [9:0]                r_ctrl;
  logic [CHAR_LEN_MAX-1:0]   r_tx_buf, r_rx_buf, r_tx_sh, r_rx_sh;
  logic [CW-1:0]             r_bitcnt;
  logic                      r_tx_empty, r_rx_valid, r_overrun;

  logic w_sclk, w_ss_n, w_mosi, w_sclk_chg, w_lead, w_trail, w_sample, w_shift;
  logic w_ss_fall, w_ss_rise, w_last, w_busy;
  logic w_cpol, w_cpha, w_lsb, w_ie, w_en;
  logic w_acc, w_wr, w_rd, w_rd_rx;
  logic [CW-1:0] w_len;
  logic [IW-1:0] w_rx_idx, w_msb_idx;
  logic [31:0]   w_tx_merge;

  assign w_cpol = r_ctrl[5];
  assign w_cpha = r_ctrl[6];
  assign w_lsb  = r_ctrl[7];
  assign w_ie   = r_ctrl[8];
  assign w_en   = r_ctrl[9];
  // char_len field 0 encodes the full register width
  assign w_len  = (r_ctrl[4:0] == 5'd0) ? CW'(CHAR_LEN_MAX) : CW'(r_ctrl[4:0]);

  // Input synchronizers; ss_n idles high so reset does not fake a selection
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_chg = w_sclk ^ r_sclk_d;
  assign w_lead     = w_sclk_chg & (r_sclk_d == w_cpol);
  assign w_trail    = w_sclk_chg & (w_sclk == w_cpol);
  assign w_sample   = w_cpha ? w_trail : w_lead;
  assign w_shift    = w_cpha ? w_lead : w_trail;
  assign w_ss_fall  = ~w_ss_n & r_ss_d;
  assign w_ss_rise  = w_ss_n & ~r_ss_d;
  assign w_last     = (r_bitcnt + CW'(1)) == w_len;
  assign w_busy     = (r_state != S_IDLE);
  assign w_rx_idx   = w_lsb ? IW'(r_bitcnt) : IW'(w_len - CW'(1) - r_bitcnt);
  assign w_msb_idx  = IW'(w_len - CW'(1));

  assign w_acc   = wb.wb_cyc_in & wb.wb_stb_in & ~r_ack;
  assign w_wr    = w_acc & wb.wb_we_in;
  assign w_rd    = w_acc & ~wb.wb_we_in;
  assign w_rd_rx = w_rd && (wb.wb_adr_in == ADR_DATA);

  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ss_fall && w_en) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = w_ss_rise ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (w_ss_rise)               w_state_nxt = S_IDLE;
        else if (w_sample && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = w_ss_n ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_merge = 32'(r_tx_buf);
    for (int b = 0; b < 4; b++)
      if (wb.wb_sel_in[b]) w_tx_merge[8*b +: 8] = wb.wb_dat_in[8*b +: 8];
  end

  // Statement order matters: bus read side effects, then the FSM datapath,
  // then bus writes, so that same-cycle collisions resolve as intended.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      r_ack      <= 1'b0;
      r_int      <= 1'b0;
      r_dat_o    <= '0;
      r_ctrl     <= '0;
      r_tx_buf   <= '0;
      r_rx_buf   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_bitcnt   <= '0;
      r_tx_empty <= 1'b1;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_int <= w_ie & (r_rx_valid | r_overrun);

      if (w_rd) begin
        case (wb.wb_adr_in)
          ADR_DATA: r_dat_o <= 32'(r_rx_buf);
          ADR_CTRL: r_dat_o <= {22'd0, r_ctrl};
          ADR_STAT: r_dat_o <= {28'd0, w_busy, r_tx_empty, r_overrun, r_rx_valid};
          default:  r_dat_o <= '0;
        endcase
      end
      if (w_rd_rx) r_rx_valid <= 1'b0;
      if (w_wr && wb.wb_adr_in == ADR_STAT && wb.wb_sel_in[0] && wb.wb_dat_in[1])
        r_overrun <= 1'b0;

      case (r_state)
        S_LOAD: begin
          r_tx_sh    <= r_tx_empty ? '0 : r_tx_buf;
          r_tx_empty <= 1'b1;
          r_rx_sh    <= '0;
          r_bitcnt   <= '0;
        end
        S_SHIFT: begin
          if (w_sample) begin
            r_rx_sh[w_rx_idx] <= w_mosi;
            r_bitcnt          <= r_bitcnt + CW'(1);
          end
          // Only shift edges after a sample advance: this skips the cpha=1
          // edge that presents bit 0, and the stray trailing edge that ends
          // the previous character in back-to-back cpha=0 transfers.
          if (w_shift && r_bitcnt != '0)
            r_tx_sh <= w_lsb ? (r_tx_sh >> 1) : (r_tx_sh << 1);
        end
        S_DONE: begin
          if (!r_rx_valid || w_rd_rx) begin
            r_rx_buf   <= r_rx_sh;
            r_rx_valid <= 1'b1;
          end else begin
            r_overrun  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_wr && wb.wb_adr_in == ADR_DATA) begin
        r_tx_buf   <= w_tx_merge[CHAR_LEN_MAX-1:0];
        r_tx_empty <= 1'b0;
      end
      if (w_wr && wb.wb_adr_in == ADR_CTRL && !w_busy) begin
        if (wb.wb_sel_in[0]) r_ctrl[7:0] <= wb.wb_dat_in[7:0];
        if (wb.wb_sel_in[1]) r_ctrl[9:8] <= wb.wb_dat_in[9:8];
      end
    end
  end

  assign wb.wb_ack_out = r_ack;
  assign wb.wb_dat_o   = r_dat_o;
  assign wb.wb_int_o   = r_int;
  assign miso_out      = w_lsb ? r_tx_sh[0] : r_tx_sh[w_msb_idx];
  assign miso_oe       = ~w_ss_n & w_en;
endmodule
